// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin memory arbiter with per-transaction timeout
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        r0_req_i,
    input  logic        r0_rw_i,
    input  logic [31:0] r0_addr_i,
    input  logic [31:0] r0_wdata_i,
    output logic [31:0] r0_rdata_o,
    output logic        r0_ack_o,
    output logic        r0_err_o,

    input  logic        r1_req_i,
    input  logic        r1_rw_i,
    input  logic [31:0] r1_addr_i,
    input  logic [31:0] r1_wdata_i,
    output logic [31:0] r1_rdata_o,
    output logic        r1_ack_o,
    output logic        r1_err_o,

    output logic        mem_req_o,
    output logic        mem_rw_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,

    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

    state_e      state_q,     state_d;
    logic [1:0]  grant_q,     grant_d;
    logic        last_r1_q,   last_r1_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic        mem_rw_q,    mem_rw_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] r0_rdata_q,  r0_rdata_d;
    logic [31:0] r1_rdata_q,  r1_rdata_d;
    logic [1:0]  ack_q,       ack_d;
    logic [1:0]  err_q,       err_d;

    logic        sel_r1;

    // On a tie the requester that was not served last wins.
    always_comb begin
        sel_r1 = 1'b0;
        if (r0_req_i && r1_req_i) begin
            sel_r1 = ~last_r1_q;
        end else if (r1_req_i) begin
            sel_r1 = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_r1_d   = last_r1_q;
        cnt_d       = cnt_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        r0_rdata_d  = r0_rdata_q;
        r1_rdata_d  = r1_rdata_q;
        ack_d       = 2'b00;
        err_d       = 2'b00;

        case (state_q)
            IDLE: begin
                if (r0_req_i || r1_req_i) begin
                    grant_d     = sel_r1 ? 2'b10 : 2'b01;
                    mem_rw_d    = sel_r1 ? r1_rw_i    : r0_rw_i;
                    mem_addr_d  = sel_r1 ? r1_addr_i  : r0_addr_i;
                    mem_wdata_d = sel_r1 ? r1_wdata_i : r0_wdata_i;
                    cnt_d       = 8'd0;
                    state_d     = BUSY;
                end
            end

            BUSY: begin
                // A completion on the final timeout cycle still counts as success.
                if (mem_ack_i) begin
                    if (!mem_rw_q) begin
                        if (grant_q[0]) r0_rdata_d = mem_rdata_i;
                        if (grant_q[1]) r1_rdata_d = mem_rdata_i;
                    end
                    ack_d   = grant_q;
                    state_d = RESP;
                end else if (cnt_q == CNT_LIMIT) begin
                    if (grant_q[0]) r0_rdata_d = 32'hFFFF_FFFF;
                    if (grant_q[1]) r1_rdata_d = 32'hFFFF_FFFF;
                    err_d   = grant_q;
                    state_d = RESP;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RESP: begin
                last_r1_d = grant_q[1];
                grant_d   = 2'b00;
                state_d   = IDLE;
            end

            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // Reset leaves the pointer on r1 so that r0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            last_r1_q   <= 1'b1;
            cnt_q       <= 8'd0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            r0_rdata_q  <= 32'd0;
            r1_rdata_q  <= 32'd0;
            ack_q       <= 2'b00;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_r1_q   <= last_r1_d;
            cnt_q       <= cnt_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            r0_rdata_q  <= r0_rdata_d;
            r1_rdata_q  <= r1_rdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    assign mem_req_o   = (state_q == BUSY);
    assign mem_rw_o    = mem_rw_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign grant_o     = grant_q;

    assign r0_rdata_o  = r0_rdata_q;
    assign r1_rdata_o  = r1_rdata_q;
    assign r0_ack_o    = ack_q[0];
    assign r1_ack_o    = ack_q[1];
    assign r0_err_o    = err_q[0];
    assign r1_err_o    = err_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r0_req, r0_rw, r1_req, r1_rw;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic [31:0] r0_rdata, r1_rdata;
    logic        r0_ack, r0_err, r1_ack, r1_err;
    logic        mem_req, mem_rw, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, mem_rdata_r;
    logic        use_model;
    logic [1:0]  grant;
    logic [3:0]  resp_flags;

    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter #(.TIMEOUT(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .r0_req_i(r0_req), .r0_rw_i(r0_rw), .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
        .r0_rdata_o(r0_rdata), .r0_ack_o(r0_ack), .r0_err_o(r0_err),
        .r1_req_i(r1_req), .r1_rw_i(r1_rw), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
        .r1_rdata_o(r1_rdata), .r1_ack_o(r1_ack), .r1_err_o(r1_err),
        .mem_req_o(mem_req), .mem_rw_o(mem_rw), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .grant_o(grant)
    );

    // Memory model: read data either a fixed word or derived from the address.
    assign mem_rdata  = use_model ? (mem_addr ^ 32'h5A5A_0000) : mem_rdata_r;
    assign resp_flags = {r1_err, r1_ack, r0_err, r0_ack};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(input int budget, input int exp_lat, input logic [1:0] drop);
        int   lat;
        logic got;
        exp_t e;
        lat = 0;
        while (lat < budget && resp_flags == 4'b0000) begin
            @(negedge clk);
            lat++;
        end
        got = (resp_flags != 4'b0000);
        check("resp_seen", {31'd0, got}, 32'd1);
        if (!got) return;
        check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check("resp_flags", {28'd0, resp_flags}, {28'd0, e.flags});
        check("resp_latency", lat, exp_lat);
        check("resp_rdata", (e.flags[1:0] != 2'b00) ? r0_rdata : r1_rdata, e.rdata);
        check("resp_mem_req", {31'd0, mem_req}, 32'd0);
        check("resp_grant", {30'd0, grant}, (e.flags[1:0] != 2'b00) ? 32'd1 : 32'd2);
        if (drop[0]) r0_req = 1'b0;
        if (drop[1]) r1_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        r0_req = 0; r0_rw = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_rw = 0; r1_addr = 0; r1_wdata = 0;
        mem_ack = 0; mem_rdata_r = 0; use_model = 0;

        // Reset state, observed before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_flags", {28'd0, resp_flags}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
        check("rst_r0_rdata", r0_rdata, 32'd0);
        check("rst_r1_rdata", r1_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Tie with zero-wait memory: grants alternate starting with r0
        @(negedge clk);
        use_model = 1; mem_ack = 1;
        r0_req = 1; r0_rw = 0; r0_addr = 32'h100;
        r1_req = 1; r1_rw = 0; r1_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sb_q.push_back('{4'b0001, 32'h5A5A_0100});
            else            sb_q.push_back('{4'b0100, 32'h5A5A_0200});
            @(negedge clk);
            check("tie_grant", {30'd0, grant}, (i % 2 == 0) ? 32'd1 : 32'd2);
            check("tie_mem_req", {31'd0, mem_req}, 32'd1);
            wait_resp(10, 1, (i == 3) ? 2'b11 : 2'b00);
            @(negedge clk);
            check("tie_idle_grant", {30'd0, grant}, 32'd0);
        end

        // Single read
        use_model = 0; mem_rdata_r = 32'hDEAD_BEEF;
        r0_req = 1; r0_rw = 0; r0_addr = 32'h10;
        sb_q.push_back('{4'b0001, 32'hDEAD_BEEF});
        @(negedge clk);
        check("rd_mem_req", {31'd0, mem_req}, 32'd1);
        check("rd_mem_addr", mem_addr, 32'h10);
        check("rd_mem_rw", {31'd0, mem_rw}, 32'd0);
        check("rd_grant", {30'd0, grant}, 32'd1);
        wait_resp(10, 1, 2'b01);
        @(negedge clk);
        check("rd_ack_pulse", {28'd0, resp_flags}, 32'd0);
        check("rd_rdata_hold", r0_rdata, 32'hDEAD_BEEF);

        // Write leaves rdata untouched
        mem_rdata_r = 32'hCAFE_F00D;
        r0_req = 1; r0_rw = 1; r0_addr = 32'h20; r0_wdata = 32'h1234_5678;
        sb_q.push_back('{4'b0001, 32'hDEAD_BEEF});
        @(negedge clk);
        check("wr_mem_rw", {31'd0, mem_rw}, 32'd1);
        check("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        wait_resp(10, 1, 2'b01);
        @(negedge clk);

        // Timeout on r1 write; request changes mid-transaction are ignored
        mem_ack = 0;
        r1_req = 1; r1_rw = 1; r1_addr = 32'h300; r1_wdata = 32'h0000_BBBB;
        sb_q.push_back('{4'b1000, 32'hFFFF_FFFF});
        @(negedge clk);
        check("to_grant", {30'd0, grant}, 32'd2);
        r0_req = 1; r1_addr = 32'hFFF0;
        @(negedge clk);
        check("to_no_preempt_grant", {30'd0, grant}, 32'd2);
        check("to_fields_stable", mem_addr, 32'h300);
        r0_req = 0; r1_addr = 32'h300;
        wait_resp(40, 15, 2'b10);
        @(negedge clk);

        // Completion on the final timeout cycle wins over the timeout
        mem_rdata_r = 32'h0BAD_C0DE;
        r1_req = 1; r1_rw = 0; r1_addr = 32'h304;
        sb_q.push_back('{4'b0100, 32'h0BAD_C0DE});
        repeat (16) @(negedge clk);
        check("edge_mem_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1;
        wait_resp(5, 1, 2'b10);
        mem_ack = 0;
        @(negedge clk);

        // Reset during BUSY abandons the transaction
        r0_req = 1; r0_rw = 0; r0_addr = 32'h400;
        @(negedge clk);
        check("rb_mem_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rb_async_mem_req", {31'd0, mem_req}, 32'd0);
        check("rb_async_grant", {30'd0, grant}, 32'd0);
        r0_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rb_no_resp", {28'd0, resp_flags}, 32'd0);
        end
        check("rb_r0_rdata", r0_rdata, 32'd0);

        use_model = 1;
        r0_req = 1; r0_addr = 32'h500;
        r1_req = 1; r1_rw = 0; r1_addr = 32'h600;
        sb_q.push_back('{4'b0001, 32'h5A5A_0500});
        @(negedge clk);
        check("rb_tie_grant", {30'd0, grant}, 32'd1);
        wait_resp(10, 1, 2'b11);
        @(negedge clk);
        check("rb_idle_grant", {30'd0, grant}, 32'd0);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
